time_keeper: RTL and testbench

TIME_KEEPER -- requirements
Module: time_keeper

---
 rtl/clock_pkg.sv | 25 ++
 rtl/bcd_pair_cnt.sv | 36 +++
 rtl/time_keeper.sv | 133 +++++++++++++
 tb/tb_time_keeper.sv | 190 +++++++++++++++++++
 4 files changed

// File: rtl/clock_pkg.sv
// clock_pkg: shared state encoding, BCD digit type and time limits for time_keeper
package clock_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        SET_HOUR = 2'd1,
        SET_MIN  = 2'd2
    } state_e;

    typedef logic [3:0] bcd_t;

    localparam logic [7:0] MAX_MS      = 8'h59;
    localparam logic [7:0] MAX_HOUR_24 = 8'h23;
    localparam logic [7:0] MAX_HOUR_12 = 8'h12;
    localparam logic [7:0] MIN_HOUR_12 = 8'h01;

    function automatic logic [7:0] bcd_inc(input logic [7:0] v);
        bcd_t tens;
        bcd_t units;
        tens  = v[7:4];
        units = v[3:0];
        return (units == 4'd9) ? {tens + 4'd1, 4'd0} : {tens, units + 4'd1};
    endfunction

endpackage

// File: rtl/bcd_pair_cnt.sv
// bcd_pair_cnt: two-digit BCD counter with min/max wrap, wrap strobe and synchronous load
module bcd_pair_cnt
    import clock_pkg::*;
#(
    parameter logic [7:0] RST_VAL = 8'h00
) (
    input  logic       clk_i,
    input  logic       rst_ni,
    input  logic       inc_i,
    input  logic       load_i,
    input  logic [7:0] load_val_i,
    input  logic [7:0] max_i,
    input  logic [7:0] min_i,
    output logic [3:0] tens_o,
    output logic [3:0] units_o,
    output logic       wrap_o
);

    logic [7:0] cnt_q, cnt_d;

    assign wrap_o  = inc_i && (cnt_q == max_i);
    assign tens_o  = cnt_q[7:4];
    assign units_o = cnt_q[3:0];

    // load beats increment; an increment at max returns to min
    always_comb begin
        cnt_d = load_i ? load_val_i : wrap_o ? min_i : inc_i ? bcd_inc(cnt_q) : cnt_q;
    end

    // counter register
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) cnt_q <= RST_VAL;
        else         cnt_q <= cnt_d;
    end

endmodule

// File: rtl/time_keeper.sv
// time_keeper: BCD hh:mm:ss clock with RUN/SET_HOUR/SET_MIN editing; CLOCK_12H_EN selects 12-hour mode with pm
module time_keeper
    import clock_pkg::*;
#(
    parameter logic [7:0] RST_HOUR = 8'h00,
    parameter logic [7:0] RST_MIN  = 8'h00
) (
    input  logic       CLK,
    input  logic       RST_N,
    input  logic       tick_1hz,
    input  logic       key_mode,
    input  logic       key_inc,
    output logic [3:0] hour_t,
    output logic [3:0] hour_u,
    output logic [3:0] min_t,
    output logic [3:0] min_u,
    output logic [3:0] sec_t,
    output logic [3:0] sec_u,
    output logic       sec_phase,
    output logic       blink_hour,
    output logic       blink_min,
    output logic       min_carry,
    output logic       pm
);

`ifdef CLOCK_12H_EN
    localparam logic [7:0] HOUR_MAX = MAX_HOUR_12;
    localparam logic [7:0] HOUR_MIN = MIN_HOUR_12;
    localparam logic [7:0] HOUR_RST = MAX_HOUR_12;
`else
    localparam logic [7:0] HOUR_MAX = MAX_HOUR_24;
    localparam logic [7:0] HOUR_MIN = 8'h00;
    localparam logic [7:0] HOUR_RST = RST_HOUR;
`endif

    state_e state_q, state_d;
    logic   blink_hour_q, blink_min_q, min_carry_q, sec_phase_q;
    logic   run, set_h, set_m, edit;
    logic   sec_inc, sec_load, sec_wrap, min_inc, min_wrap, hour_inc;

    assign run   = state_q == RUN;
    assign set_h = state_q == SET_HOUR;
    assign set_m = state_q == SET_MIN;
    // a coinciding mode key swallows the increment
    assign edit  = key_inc && !key_mode;

    assign sec_inc  = run && tick_1hz;
    assign sec_load = run && key_mode;
    assign min_inc  = (run && sec_wrap) || (set_m && edit);
    assign hour_inc = (run && min_wrap) || (set_h && edit);

    // mode key cycles RUN -> SET_HOUR -> SET_MIN -> RUN
    always_comb begin
        state_d = state_q;
        if (key_mode) state_d = run ? SET_HOUR : set_h ? SET_MIN : RUN;
    end

    // state and registered indicators, blink tracks the next state on the same edge
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            state_q      <= RUN;
            blink_hour_q <= 1'b0;
            blink_min_q  <= 1'b0;
            min_carry_q  <= 1'b0;
            sec_phase_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            blink_hour_q <= state_d == SET_HOUR;
            blink_min_q  <= state_d == SET_MIN;
            min_carry_q  <= run && min_wrap;
            if (tick_1hz) sec_phase_q <= ~sec_phase_q;
        end
    end

    assign blink_hour = blink_hour_q;
    assign blink_min  = blink_min_q;
    assign min_carry  = min_carry_q;
    assign sec_phase  = sec_phase_q;

    bcd_pair_cnt #(.RST_VAL(8'h00)) u_sec (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .inc_i     (sec_inc),
        .load_i    (sec_load),
        .load_val_i(8'h00),
        .max_i     (MAX_MS),
        .min_i     (8'h00),
        .tens_o    (sec_t),
        .units_o   (sec_u),
        .wrap_o    (sec_wrap)
    );

    bcd_pair_cnt #(.RST_VAL(RST_MIN)) u_min (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .inc_i     (min_inc),
        .load_i    (1'b0),
        .load_val_i(8'h00),
        .max_i     (MAX_MS),
        .min_i     (8'h00),
        .tens_o    (min_t),
        .units_o   (min_u),
        .wrap_o    (min_wrap)
    );

    bcd_pair_cnt #(.RST_VAL(HOUR_RST)) u_hour (
        .clk_i     (CLK),
        .rst_ni    (RST_N),
        .inc_i     (hour_inc),
        .load_i    (1'b0),
        .load_val_i(8'h00),
        .max_i     (HOUR_MAX),
        .min_i     (HOUR_MIN),
        .tens_o    (hour_t),
        .units_o   (hour_u),
        .wrap_o    ()
    );

`ifdef CLOCK_12H_EN
    logic pm_q;

    // pm flips whenever hours step from 11 to 12, by carry or by edit
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N)                                     pm_q <= 1'b0;
        else if (hour_inc && {hour_t, hour_u} == 8'h11) pm_q <= ~pm_q;
    end

    assign pm = pm_q;
`else
    assign pm = 1'b0;
`endif

endmodule

// File: tb/tb_time_keeper.sv
// tb_time_keeper: directed self-checking bench for time_keeper
module tb_time_keeper;

    logic       CLK = 1'b0;
    logic       RST_N = 1'b0;
    logic       tick_1hz = 1'b0;
    logic       key_mode = 1'b0;
    logic       key_inc = 1'b0;
    logic [3:0] hour_t, hour_u, min_t, min_u, sec_t, sec_u;
    logic       sec_phase, blink_hour, blink_min, min_carry, pm;
    logic [23:0] now;

    int n_chk = 0;
    int n_fail = 0;
    int tk = 0;
    int mc_cnt = 0;
    int bad = 0;

    always #5 CLK = ~CLK;

    time_keeper #(.RST_HOUR(8'h00), .RST_MIN(8'h00)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .tick_1hz  (tick_1hz),
        .key_mode  (key_mode),
        .key_inc   (key_inc),
        .hour_t    (hour_t),
        .hour_u    (hour_u),
        .min_t     (min_t),
        .min_u     (min_u),
        .sec_t     (sec_t),
        .sec_u     (sec_u),
        .sec_phase (sec_phase),
        .blink_hour(blink_hour),
        .blink_min (blink_min),
        .min_carry (min_carry),
        .pm        (pm)
    );

    assign now = {hour_t, hour_u, min_t, min_u, sec_t, sec_u};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step(input logic t, input logic m, input logic i);
        @(negedge CLK);
        tick_1hz = t;
        key_mode = m;
        key_inc  = i;
        @(negedge CLK);
        tick_1hz = 1'b0;
        key_mode = 1'b0;
        key_inc  = 1'b0;
        if (t) tk++;
        if (min_carry) mc_cnt++;
        if (hour_t > 2 || min_t > 5 || sec_t > 5 || hour_u > 9 || min_u > 9 || sec_u > 9) bad++;
    endtask

    task automatic ticks(input int n);
        repeat (n) step(1'b1, 1'b0, 1'b0);
    endtask

    task automatic incs(input int n);
        repeat (n) step(1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        repeat (3) @(negedge CLK);
`ifdef CLOCK_12H_EN
        check("rst_time", now, 24'h120000);
`else
        check("rst_time", now, 24'h000000);
`endif
        check("rst_phase", sec_phase, 0);
        check("rst_blink_h", blink_hour, 0);
        check("rst_blink_m", blink_min, 0);
        check("rst_carry", min_carry, 0);
        check("rst_pm", pm, 0);
        RST_N = 1'b1;

`ifdef CLOCK_12H_EN
        step(0, 1, 0);
        incs(11);
        check("h12_set11", now, 24'h110000);
        check("h12_pm_edit", pm, 0);
        step(0, 1, 0);
        incs(59);
        step(0, 1, 0);
        ticks(59);
        check("h12_115959", now, 24'h115959);
        check("h12_pm_am", pm, 0);
        ticks(1);
        check("h12_noon", now, 24'h120000);
        check("h12_pm_set", pm, 1);
        step(0, 1, 0);
        step(0, 1, 0);
        incs(59);
        step(0, 1, 0);
        ticks(59);
        check("h12_125959", now, 24'h125959);
        ticks(1);
        check("h12_wrap01", now, 24'h010000);
        check("h12_pm_keep", pm, 1);
`else
        ticks(59);
        check("run_59s", now, 24'h000059);
        check("phase_odd", sec_phase, 1);
        ticks(1);
        check("run_60s", now, 24'h000100);
        check("phase_even", sec_phase, 0);

        step(0, 1, 0);
        check("seth_blink_h", blink_hour, 1);
        check("seth_blink_m", blink_min, 0);
        incs(23);
        step(0, 1, 0);
        check("setm_blink_m", blink_min, 1);
        check("setm_blink_h", blink_hour, 0);
        incs(58);
        step(0, 1, 0);
        check("preload", now, 24'h235900);
        ticks(58);
        check("pre_235958", now, 24'h235958);
        mc_cnt = 0;
        bad = 0;
        ticks(1);
        check("t_235959", now, 24'h235959);
        check("no_carry_yet", mc_cnt, 0);
        ticks(1);
        check("day_wrap", now, 24'h000000);
        check("hour_t_0", hour_t, 0);
        check("hour_u_0", hour_u, 0);
        ticks(1);
        check("carry_once", mc_cnt, 1);
        check("bcd_legal", bad, 0);

        ticks(4);
        check("run_5s", now, 24'h000005);
        step(0, 1, 0);
        check("sec_clear", now, 24'h000000);
        incs(21);
        check("hour_21", now, 24'h210000);
        incs(5);
        check("hour_02", now, 24'h020000);
        check("blink_h_02", blink_hour, 1);
        ticks(3);
        check("set_frozen", now, 24'h020000);
        step(1, 0, 1);
        check("tick_inc_h", now, 24'h030000);
        check("tick_inc_ph", sec_phase, tk[0]);
        step(0, 1, 0);
        check("setm2_blink", blink_min, 1);
        incs(4);
        check("min_04", now, 24'h030400);
        step(0, 1, 1);
        check("mode_wins", now, 24'h030400);
        check("mode_blink_m", blink_min, 0);
        ticks(1);
        check("back_run", now, 24'h030401);
        step(0, 0, 1);
        check("run_inc_ign", now, 24'h030401);

        step(0, 1, 0);
        step(0, 1, 0);
        incs(3);
        check("edit_07", now, 24'h030700);
        @(negedge CLK);
        RST_N = 1'b0;
        tk = 0;
        #2;
        check("mid_rst_time", now, 24'h000000);
        check("mid_rst_bm", blink_min, 0);
        check("mid_rst_bh", blink_hour, 0);
        check("mid_rst_ph", sec_phase, 0);
        @(negedge CLK);
        RST_N = 1'b1;
        ticks(1);
        check("post_rst_run", now, 24'h000001);
        check("post_rst_pm", pm, 0);
`endif
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
